// File: rtl/pwm_pkg.sv
// Shared constants for the PWM stage that sits behind the free-running counter.
package pwm_pkg;

    localparam int W_DEF   = 4;
    localparam int CNT_MAX = (1 << W_DEF) - 1;

    // Last count of a W-bit period (all ones).
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/pwm_from_cntr_if.sv
// Duty-update handshake between a duty producer (master) and the PWM block (slave).
interface pwm_from_cntr_if #(
    parameter int W = pwm_pkg::W_DEF
) ();

    logic [W-1:0] duty_in;
    logic         duty_valid;
    logic         duty_ready;
    logic         duty_pending;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready,
        input  duty_pending
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready,
        output duty_pending
    );

endinterface

// File: rtl/pwm_from_cntr_cnt_wrap_det.sv
// Tracks the previous count to detect period wraps and illegal count steps.
module cnt_wrap_det
    import pwm_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] cnt,
    output logic         wrap,
    output logic         step_ok,
    output logic         prev_valid
);

    localparam logic [W-1:0] LAST = W'(cnt_max(W));

    logic [W-1:0] prev_cnt;
    logic [W-1:0] prev_inc;
    logic         aligned;

    assign prev_inc = prev_cnt + W'(1);
    assign step_ok  = (cnt == prev_cnt) | (cnt == prev_inc);

    // Until the first wrap has been seen, any zero count starts a period.
    assign wrap = (cnt == '0) & (!aligned | (prev_valid & (prev_cnt == LAST)));

    always_ff @(posedge clk) begin
        prev_cnt <= cnt;
        if (rst) begin
            prev_valid <= 1'b0;
            aligned    <= 1'b0;
        end else begin
            prev_valid <= 1'b1;
            aligned    <= aligned | wrap;
        end
    end

endmodule

// File: rtl/pwm_from_cntr.sv
// PWM generator driven by an external W-bit up-counter, with double-buffered duty.
module pwm_from_cntr
    import pwm_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     cnt,
    pwm_from_cntr_if.slave   duty,
    output logic             pwm_out,
    output logic             period_start,
    output logic             seq_err
);

    logic [W-1:0] act_duty;
    logic [W-1:0] shadow;
    logic [W-1:0] duty_eff;
    logic         wrap;
    logic         step_ok;
    logic         prev_valid;
    logic         xfer;
    logic         apply;

    cnt_wrap_det #(.W(W)) u_wrap_det (
        .clk        (clk),
        .rst        (rst),
        .cnt        (cnt),
        .wrap       (wrap),
        .step_ok    (step_ok),
        .prev_valid (prev_valid)
    );

    assign duty.duty_ready = rst | !duty.duty_pending;
    assign xfer            = duty.duty_valid & !duty.duty_pending;
    assign apply           = wrap & duty.duty_pending;

    // A pending value takes over on the wrap cycle itself so count 0 uses it.
    assign duty_eff = apply ? shadow : act_duty;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_duty          <= '0;
            shadow            <= '0;
            duty.duty_pending <= 1'b0;
            pwm_out           <= INVERT;
            period_start      <= 1'b0;
            seq_err           <= 1'b0;
        end else begin
            if (apply) begin
                act_duty          <= shadow;
                duty.duty_pending <= 1'b0;
            end else if (xfer) begin
                shadow            <= duty.duty_in;
                duty.duty_pending <= 1'b1;
            end
            pwm_out      <= (cnt < duty_eff) ^ INVERT;
            period_start <= wrap;
            seq_err      <= seq_err | (prev_valid & !step_ok);
        end
    end

endmodule

// File: tb/tb_pwm_from_cntr.sv
// Bench for pwm_from_cntr: vector table, directed period sequences, random walk vs. model.
module tb_pwm_from_cntr;
    import pwm_pkg::*;

    localparam int W = 4;
    localparam int P = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] cnt;
    logic         pwm_out, period_start, seq_err;
    logic         pwm_out_i, period_start_i, seq_err_i;

    pwm_from_cntr_if #(.W(W)) dif ();
    pwm_from_cntr_if #(.W(W)) dif_i ();

    always #5 clk = ~clk;

    pwm_from_cntr #(.W(W), .INVERT(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .cnt          (cnt),
        .duty         (dif.slave),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .seq_err      (seq_err)
    );

    pwm_from_cntr #(.W(W), .INVERT(1'b1)) dut_i (
        .clk          (clk),
        .rst          (rst),
        .cnt          (cnt),
        .duty         (dif_i.slave),
        .pwm_out      (pwm_out_i),
        .period_start (period_start_i),
        .seq_err      (seq_err_i)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: duty double buffer and count-sequence rules on plain integers.
    int m_act, m_shadow, m_prev;
    bit m_pending = 1'b0, m_aligned, m_err, m_pwm, m_ps;

    task automatic model_step(input bit r, input int c, input bit dv, input int d);
        bit wrap;
        int eff;
        if (r) begin
            m_act = 0; m_shadow = 0; m_pending = 0; m_prev = -1;
            m_aligned = 0; m_err = 0; m_pwm = 0; m_ps = 0;
            return;
        end
        wrap = (c == 0) && (!m_aligned || m_prev == P - 1);
        eff  = (wrap && m_pending) ? m_shadow : m_act;
        m_pwm = (c < eff);
        if (m_prev >= 0 && ((c - m_prev + P) % P) > 1) m_err = 1;
        if (wrap && m_pending) begin
            m_act = m_shadow;
            m_pending = 0;
        end else if (dv && !m_pending) begin
            m_shadow = d;
            m_pending = 1;
        end
        m_ps = wrap;
        if (wrap) m_aligned = 1;
        m_prev = c;
    endtask

    // One clock: drive at negedge, check ready, clock, check registered outputs.
    task automatic cyc(input bit r, input int c, input bit dv, input int d);
        rst = r;
        cnt = c[W-1:0];
        dif.duty_valid   = dv;  dif.duty_in   = d[W-1:0];
        dif_i.duty_valid = dv;  dif_i.duty_in = d[W-1:0];
        #1;
        chk("duty_ready", dif.duty_ready, r | !m_pending);
        chk("duty_ready_inv", dif_i.duty_ready, r | !m_pending);
        @(posedge clk);
        model_step(r, c, dv, d);
        @(negedge clk);
        chk("pwm_out", pwm_out, m_pwm);
        chk("pwm_out_inv", pwm_out_i, !m_pwm);
        chk("period_start", period_start, m_ps);
        chk("period_start_inv", period_start_i, m_ps);
        chk("duty_pending", dif.duty_pending, m_pending);
        chk("seq_err", seq_err, m_err);
        chk("seq_err_inv", seq_err_i, m_err);
    endtask

    task automatic period(input int dv_at, input int d, output int highs, output int highs_i);
        highs = 0;
        highs_i = 0;
        for (int k = 0; k < P; k++) begin
            cyc(1'b0, k, (k == dv_at), d);
            highs   += int'(pwm_out);
            highs_i += int'(pwm_out_i);
        end
    endtask

    typedef struct {
        bit r;
        int c;
        bit ps;
        bit err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input int c, input bit ps, input bit err);
        vec_t v;
        v.r = r; v.c = c; v.ps = ps; v.err = err;
        tbl.push_back(v);
    endfunction

    initial begin
        int h, hi, cur;
        bit r, dv;
        rst = 1'b1;
        cnt = '0;
        dif.duty_valid = 1'b0;   dif.duty_in = '0;
        dif_i.duty_valid = 1'b0; dif_i.duty_in = '0;

        // Reset, idle periods, a jump, reset recovery, stalls at 4 and at 0.
        add(1, 0, 0, 0);
        add(1, 0, 0, 0);
        add(0, 0, 1, 0);
        for (int k = 1; k < P; k++) add(0, k, 0, 0);
        add(0, 0, 1, 0);
        for (int k = 1; k <= 6; k++) add(0, k, 0, 0);
        add(0, 9, 0, 1);
        add(0, 10, 0, 1);
        add(1, 10, 0, 0);
        add(0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) add(0, k, 0, 0);
        add(0, 4, 0, 0);
        add(0, 4, 0, 0);
        for (int k = 5; k < P; k++) add(0, k, 0, 0);
        add(0, 0, 1, 0);
        add(0, 0, 0, 0);
        add(0, 0, 0, 0);

        @(negedge clk);
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].c, 1'b0, 0);
            chk($sformatf("tbl%0d_pwm", i), pwm_out, 0);
            chk($sformatf("tbl%0d_ps", i), period_start, tbl[i].ps);
            chk($sformatf("tbl%0d_pend", i), dif.duty_pending, 0);
            chk($sformatf("tbl%0d_err", i), seq_err, tbl[i].err);
        end

        // Duty 5 written mid-period, applied at the next wrap.
        cyc(1'b1, 0, 1'b0, 0);
        for (int k = 0; k < P; k++) begin
            cyc(1'b0, k, (k == 7), 5);
            if (k == 7) begin
                chk("t2_ready", dif.duty_ready, 0);
                chk("t2_pending", dif.duty_pending, 1);
            end
        end
        for (int k = 0; k < P; k++) begin
            cyc(1'b0, k, 1'b0, 0);
            chk($sformatf("t2_pwm_cnt%0d", k), pwm_out, (k < 5));
            if (k == 0) begin
                chk("t2_pend_clear", dif.duty_pending, 0);
                chk("t2_ready_back", dif.duty_ready, 1);
            end
        end

        // Duty 12 offered while 3 is still pending is refused, then accepted after the wrap.
        for (int k = 0; k < P; k++) begin
            cyc(1'b0, k, (k == 7) || (k >= 10), (k == 7) ? 3 : 12);
            if (k >= 10) chk("t3_refused_pending", dif.duty_pending, 1);
        end
        period(2, 12, h, hi);
        chk("t3_highs_duty3", h, 3);
        period(-1, 0, h, hi);
        chk("t3_highs_duty12", h, 12);

        // Transfer on the wrap cycle itself waits for the following wrap.
        period(0, 9, h, hi);
        chk("t4_highs_old12", h, 12);
        period(-1, 0, h, hi);
        chk("t4_highs_new9", h, 9);

        // Reset mid-period with 8 active and 2 pending.
        period(3, 8, h, hi);
        chk("t6_highs_9", h, 9);
        for (int k = 0; k < 10; k++) cyc(1'b0, k, (k == 3), 2);
        chk("t6_pending_before", dif.duty_pending, 1);
        cyc(1'b1, 10, 1'b0, 0);
        chk("t6_pwm_rst", pwm_out, 0);
        chk("t6_pwm_inv_rst", pwm_out_i, 1);
        chk("t6_pending_rst", dif.duty_pending, 0);
        for (int k = 11; k < P; k++) cyc(1'b0, k, 1'b0, 0);
        period(-1, 0, h, hi);
        chk("t6_highs_zero", h, 0);
        chk("t6_highs_inv_all", hi, P);

        // Largest duty: high for all but the last count.
        period(5, P - 1, h, hi);
        period(-1, 0, h, hi);
        chk("max_duty_highs", h, P - 1);
        chk("max_duty_highs_inv", hi, 1);

        // Random walk: mostly +1, some holds, rare jumps and resets.
        cur = 0;
        for (int n = 0; n < 3000; n++) begin
            int roll;
            r = ($urandom_range(149) == 0);
            roll = $urandom_range(39);
            if (roll < 4)       cur = cur;
            else if (roll == 4) cur = $urandom_range(P - 1);
            else                cur = (cur + 1) % P;
            dv = ($urandom_range(3) == 0);
            cyc(r, cur, dv, $urandom_range(P - 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_from_cntr.md
Name: pwm_from_cntr

Overview:
Downstream consumer of the free-running 4-bit up-counter output (cntr_4.y). It turns the count into a PWM waveform with a programmable duty. Duty updates arrive through a valid/ready handshake and are double-buffered, so they take effect only at a period boundary (count wrap to 0). It also flags any count sequence that breaks the +1-mod-2^W pattern.

Parameters:
W, 4, count/duty width; must match the upstream counter width
INVERT, 0, 1 = pwm_out polarity inverted (applied after the compare, at the output register)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
cnt  input  W  count from upstream counter (its y output); advances by at most 1 per clk
duty_in  input  W  requested high-time in counts per 2^W-count period
duty_valid  input  1  duty_in valid
duty_ready  output  1  block can accept duty_in this cycle
pwm_out  output  1  registered PWM output
period_start  output  1  one-cycle pulse, registered, on the cycle after cnt wraps to 0
duty_pending  output  1  a duty update is buffered, not yet applied
seq_err  output  1  sticky: illegal count step detected

Behaviour:
- Reset (rst=1 at clk edge) clears all state: act_duty=0, shadow=0, duty_pending=0, pwm_out=INVERT, period_start=0, seq_err=0, prev_valid=0. duty_ready is combinational and equals 1 while rst=1.
- prev_cnt register captures cnt every cycle. prev_valid sets 1 on the first cycle after reset.
- wrap = prev_valid & (prev_cnt == 2^W-1) & (cnt == 0).
- The first cnt==0 seen after reset also counts as a wrap, so the first period is aligned.
- step_ok = (cnt == prev_cnt) | (cnt == prev_cnt+1 mod 2^W). Holding the same count is legal, which allows a gated or slow counter.
- seq_err sets when prev_valid & !step_ok, and stays set until rst.
- Handshake:
  - duty_ready = !duty_pending.
  - Transfer occurs when duty_valid & duty_ready: shadow<=duty_in, duty_pending<=1.
  - duty_in is sampled only on a transfer.
- Apply:
  - On a wrap with duty_pending=1: act_duty<=shadow, duty_pending<=0.
  - duty_eff = (wrap & duty_pending) ? shadow : act_duty. The new duty is therefore used for cnt=0 of the new period.
- Simultaneous transfer and wrap with duty_pending=0: the value goes to shadow and is applied at the next wrap, not this one.
- Compare: pwm_out <= (cnt < duty_eff) XOR INVERT. Latency is 1 clk from cnt to pwm_out.
  - duty=0: output constantly low.
  - duty=2^W-1: high for 15 of 16 counts. 100% duty is not supported.
- period_start <= wrap, giving a 1-cycle latency aligned with pwm_out.
- rst mid-period: the pending update is discarded and the output is forced low (INVERT=0) on the next edge. Normal operation resumes at the first cnt==0.
- If cnt stalls at a value: pwm_out holds, and no wrap or period_start occurs.

Decomposition:
- Shared package (pwm_pkg): W default, constant CNT_MAX = 2^W-1.
- One natural sub-module, cnt_wrap_det: holds prev_cnt and prev_valid, produces wrap and step_ok.
- The top module holds the handshake, shadow/active registers and compare.

Test Plan:
1. Reset held 2 cycles, then cnt 0..15 repeating with no duty write -> pwm_out=0 throughout, period_start pulses 1 cycle after each cnt=0, seq_err=0.
2. Write duty=5 mid-period (cnt=7) -> duty_ready drops next cycle, duty_pending=1. After the next cnt=0, pwm_out=1 for cnt 0..4 (seen 1 clk later), 0 for 5..15. duty_pending clears, duty_ready=1.
3. Assert duty_valid with duty=12 while duty_pending=1 (previous 3 not yet applied) -> no transfer. Re-present after wrap -> 3 applies first, 12 applies one period later.
4. Transfer duty=9 exactly on the wrap cycle with pending=0 -> the period just starting uses the old duty. 9 takes effect at the following wrap.
5. Counter jumps 6->9 -> seq_err=1 next cycle and remains 1. rst -> seq_err=0. A stall 4,4,4 does not set seq_err.
6. rst pulse at cnt=10 with duty 8 active and 2 pending -> pwm_out=0, duty_pending=0 after reset. Next period runs with duty 0. INVERT=1 build: same stimulus gives the complemented pwm_out.
